des_round_engine: RTL and testbench



---
 rtl/des_round_engine.sv | 220 ++++++++++++++++++++++
 tb/tb_des_round_engine.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/des_round_engine.sv
// des_round_engine
//   Iterative DES datapath: one Feistel round per clock on a 64-bit block,
//   with round keys k1..k16 supplied (already ordered) by the key schedule.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for a block, in_ready=1
//   ROUND | one Feistel round per edge, keys selected by round (1..16)
//   DONE  | out_valid=1, data_out = FP({R,L}) held until out_ready
//
// Ports
//   clk, rst_n           clock, async active-low reset
//   in_valid/in_ready    input handshake, data_in (bit 63 = DES bit 1)
//   k1..k16              48-bit round keys (bit 47 = key bit 1), must be
//                        stable from accept until the last round edge
//   out_valid/out_ready  output handshake, data_out (same numbering)
//   busy                 high while in ROUND
module des_round_engine (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] data_in,
  input  logic [47:0] k1,
  input  logic [47:0] k2,
  input  logic [47:0] k3,
  input  logic [47:0] k4,
  input  logic [47:0] k5,
  input  logic [47:0] k6,
  input  logic [47:0] k7,
  input  logic [47:0] k8,
  input  logic [47:0] k9,
  input  logic [47:0] k10,
  input  logic [47:0] k11,
  input  logic [47:0] k12,
  input  logic [47:0] k13,
  input  logic [47:0] k14,
  input  logic [47:0] k15,
  input  logic [47:0] k16,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] data_out,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

  // Tables use DES 1-based bit numbers; bit n lives at vector index width-n.
  localparam int IP_T [64] = '{
    58, 50, 42, 34, 26, 18, 10,  2,  60, 52, 44, 36, 28, 20, 12,  4,
    62, 54, 46, 38, 30, 22, 14,  6,  64, 56, 48, 40, 32, 24, 16,  8,
    57, 49, 41, 33, 25, 17,  9,  1,  59, 51, 43, 35, 27, 19, 11,  3,
    61, 53, 45, 37, 29, 21, 13,  5,  63, 55, 47, 39, 31, 23, 15,  7};

  localparam int FP_T [64] = '{
    40,  8, 48, 16, 56, 24, 64, 32,  39,  7, 47, 15, 55, 23, 63, 31,
    38,  6, 46, 14, 54, 22, 62, 30,  37,  5, 45, 13, 53, 21, 61, 29,
    36,  4, 44, 12, 52, 20, 60, 28,  35,  3, 43, 11, 51, 19, 59, 27,
    34,  2, 42, 10, 50, 18, 58, 26,  33,  1, 41,  9, 49, 17, 57, 25};

  localparam int E_T [48] = '{
    32,  1,  2,  3,  4,  5,   4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13,  12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21,  20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29,  28, 29, 30, 31, 32,  1};

  localparam int P_T [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,   1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9,  19, 13, 30,  6, 22, 11,  4, 25};

  // Entry index = row*16 + column, row = {b1,b6}, column = b2..b5.
  localparam int SBOX [8][64] = '{
    '{14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,
       0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
       4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0,
      15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13},
    '{15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,
       3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
       0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15,
      13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9},
    '{10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8,
      13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
      13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,
       1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12},
    '{ 7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15,
      13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
      10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,
       3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14},
    '{ 2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9,
      14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
       4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14,
      11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3},
    '{12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11,
      10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
       9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,
       4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13},
    '{ 4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1,
      13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
       1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,
       6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12},
    '{13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,
       1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
       7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,
       2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11}};

  function automatic logic [63:0] ip_perm(input logic [63:0] x);
    logic [63:0] y;
    for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - IP_T[i])];
    return y;
  endfunction

  function automatic logic [63:0] fp_perm(input logic [63:0] x);
    logic [63:0] y;
    for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - FP_T[i])];
    return y;
  endfunction

  function automatic logic [31:0] f_func(input logic [31:0] rin, input logic [47:0] key);
    logic [47:0] x;
    logic [31:0] s;
    logic [31:0] y;
    logic [5:0]  six;
    for (int i = 0; i < 48; i++) x[6'(47 - i)] = rin[5'(32 - E_T[i])];
    x = x ^ key;
    for (int b = 0; b < 8; b++) begin
      six = x[6'(47 - 6 * b) -: 6];
      s[5'(31 - 4 * b) -: 4] = 4'(SBOX[3'(b)][{six[5], six[0], six[4:1]}]);
    end
    for (int i = 0; i < 32; i++) y[5'(31 - i)] = s[5'(32 - P_T[i])];
    return y;
  endfunction

  state_t      state_q, state_d;
  logic [31:0] l_q, r_q;
  // Holds 1..16 directly, so it needs a fifth bit; 0 only after reset.
  logic [4:0]  round_q;
  logic [47:0] rkey;
  logic [63:0] ip_data;
  logic [31:0] f_out;

  always_comb begin
    case (round_q)
      5'd1:    rkey = k1;
      5'd2:    rkey = k2;
      5'd3:    rkey = k3;
      5'd4:    rkey = k4;
      5'd5:    rkey = k5;
      5'd6:    rkey = k6;
      5'd7:    rkey = k7;
      5'd8:    rkey = k8;
      5'd9:    rkey = k9;
      5'd10:   rkey = k10;
      5'd11:   rkey = k11;
      5'd12:   rkey = k12;
      5'd13:   rkey = k13;
      5'd14:   rkey = k14;
      5'd15:   rkey = k15;
      5'd16:   rkey = k16;
      default: rkey = k1;
    endcase
  end

  assign ip_data  = ip_perm(data_in);
  assign f_out    = f_func(r_q, rkey);
  // Output comes straight from the state registers, so it is stable in DONE.
  assign data_out = fp_perm({r_q, l_q});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = ROUND;
      end
      ROUND: begin
        busy = 1'b1;
        if (round_q == 5'd16) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      l_q     <= '0;
      r_q     <= '0;
      round_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            l_q     <= ip_data[63:32];
            r_q     <= ip_data[31:0];
            round_q <= 5'd1;
          end
        end
        ROUND: begin
          l_q <= r_q;
          r_q <= l_q ^ f_out;
          // Stop at 16 rather than wrapping; the FSM leaves ROUND here.
          if (round_q != 5'd16) round_q <= round_q + 5'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_des_round_engine.sv
// Bench for des_round_engine: full DES reference (key schedule + rounds)
// built from the DES rules, driven with known vectors and random blocks.
module tb_des_round_engine;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] data_in;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] data_out;
  logic        busy;
  logic [47:0] ks [16];

  int n_tests = 0;
  int n_fail  = 0;

  des_round_engine dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .data_in(data_in),
    .k1(ks[0]),   .k2(ks[1]),   .k3(ks[2]),   .k4(ks[3]),
    .k5(ks[4]),   .k6(ks[5]),   .k7(ks[6]),   .k8(ks[7]),
    .k9(ks[8]),   .k10(ks[9]),  .k11(ks[10]), .k12(ks[11]),
    .k13(ks[12]), .k14(ks[13]), .k15(ks[14]), .k16(ks[15]),
    .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // IP, FP and E follow regular patterns and are generated; the rest are tables.
  int ip_tab [64];
  int fp_tab [64];
  int e_tab  [48];
  int p_tab  [32] = '{16,7,20,21,29,12,28,17,1,15,23,26,5,18,31,10,
                      2,8,24,14,32,27,3,9,19,13,30,6,22,11,4,25};
  int pc1_tab [56] = '{57,49,41,33,25,17,9,1,58,50,42,34,26,18,
                       10,2,59,51,43,35,27,19,11,3,60,52,44,36,
                       63,55,47,39,31,23,15,7,62,54,46,38,30,22,
                       14,6,61,53,45,37,29,21,13,5,28,20,12,4};
  int pc2_tab [48] = '{14,17,11,24,1,5,3,28,15,6,21,10,
                       23,19,12,4,26,8,16,7,27,20,13,2,
                       41,52,31,37,47,55,30,40,51,45,33,48,
                       44,49,39,56,34,53,46,42,50,36,29,32};
  int shift_tab [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
  int s_tab [8][64] = '{
    '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
      4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
    '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
      0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
    '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
      13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
    '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
      10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
    '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
      4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
    '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
      9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
    '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
      1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
    '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
      7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}};

  task automatic init_tables();
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        ip_tab[8 * r + c] = ((r < 4) ? (58 + 2 * r) : (57 + 2 * (r - 4))) - 8 * c;
    for (int i = 0; i < 64; i++) fp_tab[ip_tab[i] - 1] = i + 1;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 6; j++)
        e_tab[6 * i + j] = ((4 * i + j + 31) % 32) + 1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic build_keys(input logic [63:0] key, input bit decrypt);
    logic [55:0] cd;
    logic [27:0] c, d;
    logic [47:0] k;
    for (int j = 0; j < 56; j++) cd[6'(55 - j)] = key[6'(64 - pc1_tab[j])];
    c = cd[55:28];
    d = cd[27:0];
    for (int i = 0; i < 16; i++) begin
      for (int s = 0; s < shift_tab[i]; s++) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
      cd = {c, d};
      for (int j = 0; j < 48; j++) k[6'(47 - j)] = cd[6'(56 - pc2_tab[j])];
      if (decrypt) ks[15 - i] = k;
      else         ks[i] = k;
    end
  endtask

  function automatic logic [31:0] f_ref(input logic [31:0] rr, input logic [47:0] kk);
    logic [47:0] x;
    logic [31:0] s, o;
    logic [5:0]  six;
    int row, col;
    for (int j = 0; j < 48; j++) x[6'(47 - j)] = rr[5'(32 - e_tab[j])];
    x = x ^ kk;
    for (int b = 0; b < 8; b++) begin
      six = x[6'(47 - 6 * b) -: 6];
      row = int'(six[5]) * 2 + int'(six[0]);
      col = int'(six[4:1]);
      s[5'(31 - 4 * b) -: 4] = 4'(s_tab[b][row * 16 + col]);
    end
    for (int j = 0; j < 32; j++) o[5'(31 - j)] = s[5'(32 - p_tab[j])];
    return o;
  endfunction

  function automatic logic [63:0] des_ref(input logic [63:0] blk);
    logic [63:0] p, q;
    logic [31:0] lh, rh, t;
    for (int i = 0; i < 64; i++) p[6'(63 - i)] = blk[6'(64 - ip_tab[i])];
    lh = p[63:32];
    rh = p[31:0];
    for (int i = 0; i < 16; i++) begin
      t  = rh;
      rh = lh ^ f_ref(rh, ks[i]);
      lh = t;
    end
    p = {rh, lh};
    for (int i = 0; i < 64; i++) q[6'(63 - i)] = p[6'(64 - fp_tab[i])];
    return q;
  endfunction

  // One block: accept, optional in_valid pulse mid-round, bp cycles of backpressure.
  task automatic run_block(input string tag, input logic [63:0] din, input logic [63:0] exp,
                           input int bp, input bit glitch);
    int lat;
    bit stable;
    out_ready = (bp == 0);
    @(negedge clk);
    chk({tag, " in_ready idle"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    data_in  = din;
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      #1;
      in_valid = 1'b0;
      if (glitch && lat == 5) begin
        in_valid = 1'b1;
        data_in  = ~din;
      end
      if (lat == 8) chk({tag, " busy mid"}, 64'({busy, in_ready}), 64'b10);
    end while (!out_valid && lat < 40);
    chk({tag, " latency"}, 64'(lat), 64'd17);
    chk({tag, " data"}, data_out, exp);
    if (bp > 0) begin
      stable = 1'b1;
      repeat (bp) begin
        @(posedge clk);
        #1;
        if (!out_valid || in_ready || data_out !== exp) stable = 1'b0;
      end
      chk({tag, " backpressure hold"}, 64'(stable), 64'd1);
      out_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    chk({tag, " post handshake"}, 64'({out_valid, in_ready}), 64'b01);
  endtask

  task automatic abort_block(input logic [63:0] din);
    int lat;
    bit quiet;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b1;
    data_in  = din;
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      #1;
      in_valid = 1'b0;
    end while (lat < 8);
    chk("abort busy before reset", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("abort flags", 64'({out_valid, busy, in_ready}), 64'b001);
    chk("abort data_out", data_out, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    quiet = 1'b1;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (out_valid || busy) quiet = 1'b0;
    end
    chk("abort no stale output", 64'(quiet), 64'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] key, pt, ct;
    init_tables();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    data_in   = '0;
    build_keys(64'd0, 1'b0);
    #12;
    chk("reset in_ready", 64'(in_ready), 64'd1);
    chk("reset out_valid", 64'(out_valid), 64'd0);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset data_out", data_out, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    build_keys(64'h133457799BBCDFF1, 1'b0);
    run_block("enc", 64'h0123456789ABCDEF, 64'h85E813540F0AB405, 0, 1'b0);
    build_keys(64'h133457799BBCDFF1, 1'b1);
    run_block("dec", 64'h85E813540F0AB405, 64'h0123456789ABCDEF, 0, 1'b0);
    build_keys(64'h0E329232EA6D0D73, 1'b0);
    run_block("vec8787", 64'h8787878787878787, 64'h0000000000000000, 0, 1'b0);
    build_keys(64'h0000000000000000, 1'b0);
    run_block("veczero glitch", 64'h0000000000000000, 64'h8CA64DE9C1B123A7, 0, 1'b1);
    build_keys(64'h133457799BBCDFF1, 1'b0);
    run_block("enc bp10", 64'h0123456789ABCDEF, 64'h85E813540F0AB405, 10, 1'b0);

    build_keys(64'h0E329232EA6D0D73, 1'b0);
    abort_block(64'h0123456789ABCDEF);
    build_keys(64'h133457799BBCDFF1, 1'b0);
    run_block("after abort", 64'h0123456789ABCDEF, 64'h85E813540F0AB405, 0, 1'b0);

    for (int n = 0; n < 8; n++) begin
      key = {$urandom, $urandom};
      pt  = {$urandom, $urandom};
      build_keys(key, 1'b0);
      ct = des_ref(pt);
      run_block($sformatf("rnd%0d enc", n), pt, ct, int'($urandom_range(0, 3)), 1'(n % 2));
      build_keys(key, 1'b1);
      run_block($sformatf("rnd%0d dec", n), ct, pt, 0, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
